// File: rtl/ahb_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_tb_pkg
// Description : Shared AHB-Lite encodings for the bench-bus slave model:
//               transfer type, response, burst type and the data-phase
//               responder state machine.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_tb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    // Data-phase responder states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } resp_state_e;

endpackage : ahb_tb_pkg
`default_nettype wire

// File: rtl/ahb_wait_gen.sv
`default_nettype none
// ============================================================================
// Module      : ahb_wait_gen
// Description : Per-transfer wait-state count generator. Fixed mode returns
//               WAIT_CYCLES; random mode returns lfsr % (WAIT_CYCLES+1) from
//               a 16-bit Fibonacci LFSR (taps 16,14,13,11).
// Ports       : hclk, hresetn (async, active-low)
//               i_advance  - step the LFSR (one pulse per captured transfer)
//               o_wait_cnt - wait count for a transfer captured this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_wait_gen #(
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       i_advance,
    output logic [3:0] o_wait_cnt
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    // Right-shifting form: bit 0 is tap 16, bits 2/3/5 are taps 14/13/11.
    assign w_feedback = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_advance) begin
            r_lfsr <= {w_feedback, r_lfsr[15:1]};
        end
    end

    generate
        if (WAIT_MODE == 1) begin : g_random
            assign o_wait_cnt = 4'(r_lfsr % 16'(WAIT_CYCLES + 1));
        end else begin : g_fixed
            logic w_unused_lfsr;
            assign w_unused_lfsr = ^r_lfsr;
            assign o_wait_cnt    = 4'(WAIT_CYCLES);
        end
    endgenerate

endmodule : ahb_wait_gen
`default_nettype wire

// File: rtl/ahb_slv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slv_mem_responder
// Description : AHB-Lite slave model backed by a word-addressed memory, with
//               fixed or random wait states, two-cycle ERROR responses (error
//               window, misaligned, oversize), single-master grant with hlock
//               hold, and saturating transfer statistics.
// Ports       : hclk, hresetn (async, active-low)
//               haddr/htrans/hwrite/hsize/hburst/hwdata - AHB master inputs
//               hbusreq/hlock - arbitration request inputs
//               hrdata/hready/hresp - registered slave response
//               hgrant/hmaster - registered arbitration outputs
//               stat_rd/stat_wr/stat_err - completed transfer counters
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slv_mem_responder
    import ahb_tb_pkg::*;
#(
    parameter int          DATA_W      = 64,
    parameter int          ADDR_W      = 32,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_MODE   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hF000_0000,
    parameter logic [31:0] ERR_SIZE    = 32'h1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hbusreq,
    input  logic              hlock,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic [1:0]        hresp,
    output logic              hgrant,
    output logic [3:0]        hmaster,
    output logic [31:0]       stat_rd,
    output logic [31:0]       stat_wr,
    output logic [31:0]       stat_err
);

    localparam int          c_BYTES  = DATA_W / 8;
    localparam int          c_OFF_W  = $clog2(c_BYTES);
    localparam int          c_IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [63:0] c_ERR_LO = 64'(ERR_BASE);
    localparam logic [63:0] c_ERR_HI = 64'(ERR_BASE) + 64'(ERR_SIZE);

    // Byte lanes touched by a transfer of 2^size bytes at byte offset off.
    function automatic logic [c_BYTES-1:0] f_lane_mask(input logic [c_OFF_W-1:0] off,
                                                       input logic [2:0]         size);
        logic [c_BYTES-1:0] m;
        int                 lo;
        int                 n;
        m  = '0;
        lo = int'(off);
        n  = 1 << size;
        for (int b = 0; b < c_BYTES; b++) begin
            m[b] = (b >= lo) && (b < lo + n);
        end
        return m;
    endfunction

    resp_state_e        r_state;
    resp_state_e        w_next;
    logic               r_hready;
    logic [1:0]         r_hresp;
    logic [DATA_W-1:0]  r_hrdata;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_write;
    logic [c_BYTES-1:0] r_mask;
    logic               r_err;
    logic [3:0]         r_wcnt;
    logic               r_hgrant;
    logic [3:0]         r_hmaster;
    logic [31:0]        r_stat_rd;
    logic [31:0]        r_stat_wr;
    logic [31:0]        r_stat_err;
    logic [DATA_W-1:0]  r_mem [MEM_DEPTH];

    logic               w_cap;
    logic [c_IDX_W-1:0] w_cap_idx;
    logic [c_BYTES-1:0] w_cap_mask;
    logic               w_cap_err;
    logic [3:0]         w_wait;
    logic [63:0]        w_addr64;
    logic               w_in_win;
    logic [7:0]         w_size_bytes;
    logic               w_oversize;
    logic               w_misalign;
    logic               w_rd_next;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_fwd;
    logic [DATA_W-1:0]  w_rd_word;
    logic               w_unused_ok;

    assign w_unused_ok = ^hburst;

    // hready is registered, so a capture only happens in IDLE/DATA/ERR2.
    assign w_cap = r_hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    assign w_addr64     = 64'(haddr);
    assign w_in_win     = (ERR_SIZE != 32'd0) && (w_addr64 >= c_ERR_LO) && (w_addr64 < c_ERR_HI);
    assign w_size_bytes = 8'd1 << hsize;
    assign w_oversize   = w_size_bytes > 8'(c_BYTES);
    assign w_misalign   = |({1'b0, haddr[6:0]} & (w_size_bytes - 8'd1));
    assign w_cap_err    = w_in_win || w_misalign || w_oversize;
    assign w_cap_idx    = haddr[c_OFF_W +: c_IDX_W];
    assign w_cap_mask   = f_lane_mask(haddr[c_OFF_W-1:0], hsize);

    ahb_wait_gen #(
        .WAIT_MODE   (WAIT_MODE),
        .WAIT_CYCLES (WAIT_CYCLES),
        .LFSR_SEED   (LFSR_SEED)
    ) u_wait_gen (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .i_advance  (w_cap),
        .o_wait_cnt (w_wait)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_cap) begin
                    if (w_wait != 4'd0)  w_next = ST_WAIT;
                    else if (w_cap_err)  w_next = ST_ERR1;
                    else                 w_next = ST_DATA;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wcnt == 4'd1) w_next = r_err ? ST_ERR1 : ST_DATA;
            end
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    // Read data for the transfer whose data phase starts next. A write that
    // completes on this same edge to the same word is merged in byte-wise,
    // since the memory array only updates on that edge.
    assign w_rd_next = w_cap ? !hwrite : !r_write;
    assign w_rd_idx  = w_cap ? w_cap_idx : r_idx;
    assign w_fwd     = (r_state == ST_DATA) && r_write && (r_idx == w_rd_idx);

    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        for (int b = 0; b < c_BYTES; b++) begin
            if (w_fwd && r_mask[b]) w_rd_word[8*b +: 8] = hwdata[8*b +: 8];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= ST_IDLE;
            r_hready <= 1'b1;
            r_hresp  <= HRESP_OKAY;
            r_hrdata <= '0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_mask   <= '0;
            r_err    <= 1'b0;
            r_wcnt   <= 4'd0;
        end else begin
            r_state  <= w_next;
            r_hready <= (w_next == ST_IDLE) || (w_next == ST_DATA) || (w_next == ST_ERR2);
            r_hresp  <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            if (w_cap) begin
                r_idx   <= w_cap_idx;
                r_write <= hwrite;
                r_mask  <= w_cap_mask;
                r_err   <= w_cap_err;
                r_wcnt  <= w_wait;
            end else if (r_state == ST_WAIT) begin
                r_wcnt  <= r_wcnt - 4'd1;
            end
            if ((w_next == ST_DATA) && w_rd_next) r_hrdata <= w_rd_word;
        end
    end

    // Erroring transfers never reach DATA, so they can never write memory.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= DATA_W'(i);
        end else if ((r_state == ST_DATA) && r_write) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (r_mask[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_hgrant  <= 1'b0;
            r_hmaster <= 4'd0;
        end else begin
            if (hbusreq)     r_hgrant <= 1'b1;
            else if (!hlock) r_hgrant <= 1'b0;
            if (r_hready)    r_hmaster <= r_hgrant ? 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_stat_rd  <= 32'd0;
            r_stat_wr  <= 32'd0;
            r_stat_err <= 32'd0;
        end else begin
            if ((r_state == ST_DATA) && !r_write && (r_stat_rd != '1))  r_stat_rd  <= r_stat_rd + 32'd1;
            if ((r_state == ST_DATA) && r_write && (r_stat_wr != '1))   r_stat_wr  <= r_stat_wr + 32'd1;
            if ((r_state == ST_ERR2) && (r_stat_err != '1))             r_stat_err <= r_stat_err + 32'd1;
        end
    end

    assign hrdata   = r_hrdata;
    assign hready   = r_hready;
    assign hresp    = r_hresp;
    assign hgrant   = r_hgrant;
    assign hmaster  = r_hmaster;
    assign stat_rd  = r_stat_rd;
    assign stat_wr  = r_stat_wr;
    assign stat_err = r_stat_err;

endmodule : ahb_slv_mem_responder
`default_nettype wire

// File: tb/tb_ahb_slv_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slv_mem_responder
// Description : Self-checking bench. dut0 uses default parameters (zero
//               wait), dut1 uses WAIT_CYCLES=3; both share the master inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slv_mem_responder;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [63:0] hwdata;
    logic        hbusreq;
    logic        hlock;

    logic [63:0] hrdata0, hrdata1;
    logic        hready0, hready1;
    logic [1:0]  hresp0, hresp1;
    logic        hgrant0, hgrant1;
    logic [3:0]  hmaster0, hmaster1;
    logic [31:0] stat_rd0, stat_wr0, stat_err0;
    logic [31:0] stat_rd1, stat_wr1, stat_err1;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_slv_mem_responder dut0 (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hbusreq(hbusreq), .hlock(hlock), .hrdata(hrdata0), .hready(hready0),
        .hresp(hresp0), .hgrant(hgrant0), .hmaster(hmaster0),
        .stat_rd(stat_rd0), .stat_wr(stat_wr0), .stat_err(stat_err0)
    );

    ahb_slv_mem_responder #(.WAIT_CYCLES(3)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hbusreq(hbusreq), .hlock(hlock), .hrdata(hrdata1), .hready(hready1),
        .hresp(hresp1), .hgrant(hgrant1), .hmaster(hmaster1),
        .stat_rd(stat_rd1), .stat_wr(stat_wr1), .stat_err(stat_err1)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w, input logic [2:0] s);
        haddr  = a;
        htrans = t;
        hwrite = w;
        hsize  = s;
    endtask

    // Counts hready1-low cycles up to the first hready1-high negedge.
    task automatic wait_ready1(output int lows, output bit ok);
        lows = 0;
        ok   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge hclk);
            if (hready1) begin
                ok = 1'b1;
                break;
            end
            lows++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  exp_rd, exp_wr, exp_err, lows;
        bit  ok;

        vecs[0]  = '{32'h0000_0010, 1'b0, 3'd3, 64'h0, 64'h2, 1'b0};
        vecs[1]  = '{32'h0000_0000, 1'b0, 3'd3, 64'h0, 64'h0, 1'b0};
        vecs[2]  = '{32'h0000_0030, 1'b1, 3'd3, 64'h1122_3344_5566_7788, 64'h0, 1'b0};
        vecs[3]  = '{32'h0000_0030, 1'b0, 3'd3, 64'h0, 64'h1122_3344_5566_7788, 1'b0};
        vecs[4]  = '{32'h0000_0021, 1'b1, 3'd0, 64'h0000_0000_0000_AA00, 64'h0, 1'b0};
        vecs[5]  = '{32'h0000_0020, 1'b0, 3'd3, 64'h0, 64'h0000_0000_0000_AA04, 1'b0};
        vecs[6]  = '{32'h0000_0003, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1};
        vecs[7]  = '{32'hF000_0004, 1'b0, 3'd2, 64'h0, 64'h0, 1'b1};
        vecs[8]  = '{32'h0000_0000, 1'b0, 3'd3, 64'h0, 64'h0, 1'b0};
        vecs[9]  = '{32'h0000_0040, 1'b0, 3'd4, 64'h0, 64'h0, 1'b1};
        vecs[10] = '{32'h0000_0044, 1'b1, 3'd2, 64'hCAFE_BABE_0000_0000, 64'h0, 1'b0};
        vecs[11] = '{32'h0000_0040, 1'b0, 3'd3, 64'h0, 64'hCAFE_BABE_0000_0008, 1'b0};
        vecs[12] = '{32'hF000_0FF8, 1'b0, 3'd3, 64'h0, 64'h0, 1'b1};
        vecs[13] = '{32'hF000_1000, 1'b0, 3'd3, 64'h0, 64'h0, 1'b0};
        vecs[14] = '{32'hEFFF_FFF8, 1'b0, 3'd3, 64'h0, 64'hFF, 1'b0};
        vecs[15] = '{32'h0000_0006, 1'b0, 3'd2, 64'h0, 64'h0, 1'b1};
        vecs[16] = '{32'h0000_0016, 1'b0, 3'd1, 64'h0, 64'h2, 1'b0};

        hresetn = 1'b0;
        drive(32'h0, 2'd0, 1'b0, 3'd3);
        hburst  = 3'd0;
        hwdata  = 64'h0;
        hbusreq = 1'b0;
        hlock   = 1'b0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("rst_hready0", 64'(hready0), 64'd1);
        chk("rst_hresp0", 64'(hresp0), 64'd0);
        chk("rst_hrdata0", hrdata0, 64'd0);
        chk("rst_hgrant0", 64'(hgrant0), 64'd0);
        chk("rst_hmaster0", 64'(hmaster0), 64'd0);
        chk("rst_stats0", {stat_rd0, stat_wr0 | stat_err0}, 64'd0);
        chk("rst_hready1", 64'(hready1), 64'd1);
        hresetn = 1'b1;

        // Arbiter: grant, master switch, lock hold, release.
        @(posedge hclk); #1 hbusreq = 1'b1;
        @(posedge hclk); @(negedge hclk);
        chk("arb_grant", 64'(hgrant0), 64'd1);
        chk("arb_master_lag", 64'(hmaster0), 64'd0);
        @(posedge hclk); @(negedge hclk);
        chk("arb_master", 64'(hmaster0), 64'd1);
        hbusreq = 1'b0; hlock = 1'b1;
        @(posedge hclk); @(negedge hclk);
        chk("arb_lock_hold", 64'(hgrant0), 64'd1);
        hlock = 1'b0;
        @(posedge hclk); @(negedge hclk);
        chk("arb_release", 64'(hgrant0), 64'd0);
        chk("arb_master_hold", 64'(hmaster0), 64'd1);
        @(posedge hclk); @(negedge hclk);
        chk("arb_master_clr", 64'(hmaster0), 64'd0);

        // Table of single zero-wait transfers on dut0.
        exp_rd = 0; exp_wr = 0; exp_err = 0;
        for (int i = 0; i < NVEC; i++) begin
            @(posedge hclk); #1;
            drive(vecs[i].addr, 2'd2, vecs[i].wr, vecs[i].size);
            @(posedge hclk); #1;
            htrans = 2'd0;
            hwdata = vecs[i].wdata;
            @(negedge hclk);
            if (vecs[i].err) begin
                exp_err++;
                chk($sformatf("v%0d_err1_ready", i), 64'(hready0), 64'd0);
                chk($sformatf("v%0d_err1_resp", i), 64'(hresp0), 64'd1);
                @(posedge hclk); @(negedge hclk);
                chk($sformatf("v%0d_err2_ready", i), 64'(hready0), 64'd1);
                chk($sformatf("v%0d_err2_resp", i), 64'(hresp0), 64'd1);
            end else begin
                chk($sformatf("v%0d_ready", i), 64'(hready0), 64'd1);
                chk($sformatf("v%0d_resp", i), 64'(hresp0), 64'd0);
                if (vecs[i].wr) exp_wr++;
                else begin
                    exp_rd++;
                    chk($sformatf("v%0d_rdata", i), hrdata0, vecs[i].rdata);
                end
            end
        end

        // Back-to-back write then read of the same word: forwarded data.
        @(posedge hclk); #1 drive(32'h8, 2'd2, 1'b1, 3'd3);
        @(posedge hclk); #1;
        hwdata = 64'hDEAD_BEEF_0123_4567;
        drive(32'h8, 2'd2, 1'b0, 3'd3);
        @(negedge hclk);
        chk("fwd_wr_ready", 64'(hready0), 64'd1);
        @(posedge hclk); #1 htrans = 2'd0;
        @(negedge hclk);
        chk("fwd_rd_ready", 64'(hready0), 64'd1);
        chk("fwd_rdata", hrdata0, 64'hDEAD_BEEF_0123_4567);
        exp_wr++; exp_rd++;

        // Error, IDLE during ERR1, new read captured on the ERR2 edge.
        @(posedge hclk); #1 drive(32'hF000_0010, 2'd2, 1'b0, 3'd3);
        @(posedge hclk); #1 htrans = 2'd0;
        @(negedge hclk);
        chk("b2b_err1", {62'd0, hready0, hresp0[0]}, 64'b01);
        @(posedge hclk); #1 drive(32'h10, 2'd2, 1'b0, 3'd3);
        @(negedge hclk);
        chk("b2b_err2", {62'd0, hready0, hresp0[0]}, 64'b11);
        @(posedge hclk); #1 htrans = 2'd0;
        @(negedge hclk);
        chk("b2b_data", {62'd0, hready0, hresp0[0]}, 64'b10);
        chk("b2b_rdata", hrdata0, 64'h2);
        exp_err++; exp_rd++;
        @(posedge hclk); @(negedge hclk);
        chk("stat_rd0", 64'(stat_rd0), 64'(exp_rd));
        chk("stat_wr0", 64'(stat_wr0), 64'(exp_wr));
        chk("stat_err0", 64'(stat_err0), 64'(exp_err));

        // Fresh reset, then INCR4 read on dut1 with 3 wait states per beat.
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        chk("rst2_stat_rd1", 64'(stat_rd1), 64'd0);
        hburst = 3'b011;
        @(posedge hclk); #1 drive(32'h0, 2'd2, 1'b0, 3'd3);
        @(posedge hclk); #1 drive(32'h8, 2'd3, 1'b0, 3'd3);
        for (int b = 0; b < 4; b++) begin
            wait_ready1(lows, ok);
            chk($sformatf("incr4_b%0d_timeout", b), 64'(ok), 64'd1);
            chk($sformatf("incr4_b%0d_waits", b), 64'(lows), 64'd3);
            chk($sformatf("incr4_b%0d_rdata", b), hrdata1, 64'(b));
            chk($sformatf("incr4_b%0d_resp", b), 64'(hresp1), 64'd0);
            @(posedge hclk); #1;
            if (b + 2 <= 3) drive(32'((b + 2) * 8), 2'd3, 1'b0, 3'd3);
            else            htrans = 2'd0;
        end
        @(negedge hclk);
        chk("incr4_stat_rd1", 64'(stat_rd1), 64'd4);
        hburst = 3'd0;

        // Reset during the WAIT of a write on dut1 aborts it.
        @(posedge hclk); #1 drive(32'h8, 2'd2, 1'b1, 3'd3);
        @(posedge hclk); #1;
        htrans = 2'd0;
        hwdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge hclk);
        chk("rstw_in_wait", 64'(hready1), 64'd0);
        #2 hresetn = 1'b0;
        #1;
        chk("rstw_async_ready", 64'(hready1), 64'd1);
        chk("rstw_async_resp", 64'(hresp1), 64'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk); #1 drive(32'h8, 2'd2, 1'b0, 3'd3);
        @(posedge hclk); #1 htrans = 2'd0;
        wait_ready1(lows, ok);
        chk("rstw_rd_timeout", 64'(ok), 64'd1);
        chk("rstw_rd_waits", 64'(lows), 64'd3);
        chk("rstw_rd_init", hrdata1, 64'h1);
        chk("rstw_stat_wr1", 64'(stat_wr1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ahb_slv_mem_responder
`default_nettype wire

// File: doc/ahb_slv_mem_responder.md
# ahb_slv_mem_responder

Parametrised AHB-Lite slave model for the testbench, replacing the counter-based responder on the bench bus. It is backed by a word-addressed memory, so writes can be read back. It supports configurable wait states (fixed or LFSR-random) and AHB two-cycle ERROR responses for an address window, unaligned transfers and oversize transfers. It keeps the single-master grant logic and adds hlock-aware grant release plus transfer statistics counters.

## Interface
Parameters:
- DATA_W, 64: data bus width; 32 or 64.
- ADDR_W, 32: haddr width.
- MEM_DEPTH, 256: memory depth in DATA_W words; power of two.
- WAIT_MODE, 0: 0 = fixed WAIT_CYCLES per transfer; 1 = LFSR-random in 0..WAIT_CYCLES.
- WAIT_CYCLES, 0: wait-state count (fixed) or maximum wait states (random); 0..15.
- ERR_BASE, 32'hF000_0000: base of the error window.
- ERR_SIZE, 32'h1000: size of the error window in bytes; 0 disables the window.
- LFSR_SEED, 16'hACE1: reset seed for the wait LFSR.

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset; asynchronous, active-low
- haddr  in  ADDR_W  address
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hburst  in  3  burst type (recorded only; not checked)
- hwdata  in  DATA_W  write data
- hbusreq  in  1  bus request
- hlock  in  1  locked transfer request
- hrdata  out  DATA_W  read data
- hready  out  1  transfer done
- hresp  out  2  OKAY/ERROR
- hgrant  out  1  bus grant
- hmaster  out  4  current master number
- stat_rd / stat_wr / stat_err  out  32 each  completed read, write and error transfer counts

## Operation
- Address phase accepted on an edge where hready=1 and htrans is NONSEQ or SEQ. The block captures addr, write, size and the error flag.
- IDLE and BUSY: never captured; zero-wait OKAY.
- Error flag is set when any of these hold:
  - addr is in [ERR_BASE, ERR_BASE+ERR_SIZE);
  - addr is misaligned to hsize;
  - 2^hsize > DATA_W/8.
- Memory index = addr[$clog2(DATA_W/8) +: $clog2(MEM_DEPTH)]. The index wraps silently. On reset, word i is set to i, zero-extended.
- Data-phase FSM:
  - IDLE: no transfer in flight; outputs hready=1, hresp=OKAY.
  - On a capture, the FSM goes to WAIT if the wait count is >0, else to DATA. An erroring transfer goes to ERR1 after its wait states.
  - WAIT: hready=0, hresp=OKAY; the wait counter decrements to 0, then the FSM moves to DATA or ERR1.
  - DATA: hready=1, hresp=OKAY; the transfer completes on this edge.
    - Write: hwdata byte lanes selected by size and addr are written to memory.
    - Read: hrdata holds the word.
    - Next state is WAIT/DATA/ERR1 if a new transfer is captured on the same edge, else IDLE.
  - ERR1: hready=0, hresp=ERROR. Always followed by ERR2.
  - ERR2: hready=1, hresp=ERROR. Memory is never written for an erroring transfer. Back-to-back capture is allowed on this edge.
- Write-to-read forwarding: if a read's data phase immediately follows a write to the same index, hrdata merges the write bytes.
- hrdata is only defined while hready=1 in DATA of a read; otherwise it holds its previous value.
- Wait LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per captured transfer. The wait count is lfsr % (WAIT_CYCLES+1).
- Arbiter:
  - hgrant set when hbusreq=1.
  - hgrant cleared when hbusreq=0 and hlock=0.
  - hmaster <= 1 on an edge with hgrant && hready; <= 0 on an edge with !hgrant && hready.
- Statistics: each counter increments by 1 on the completing edge (DATA edge for rd/wr, ERR2 edge for err). Counters saturate at 2^32-1.

## Timing
- Reset values: hready=1, hresp=OKAY, hrdata=0, hgrant=0, hmaster=0, all stat_* = 0. FSM=IDLE, LFSR=LFSR_SEED.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Zero-wait read: address at edge N; data valid with hready=1 during cycle N+1.
- With k wait states: hready=0 for k cycles, then hready=1 for one cycle.
- Error response: exactly two cycles with hresp=ERROR; hready is 0 then 1.
- Reset asserted mid-transfer aborts the transfer with no memory write. Outputs return to their reset values asynchronously.
- A master may change htrans to IDLE during ERR1. The block ignores it; only the ERR2 edge samples the next address.

## Structure
- Shared package ahb_tb_pkg holds:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - hresp_e (OKAY=0, ERROR=1);
  - hburst_e;
  - the resp_state_e FSM enum.
  These replace the macro.vh defines for this block.
- One sub-module, ahb_wait_gen, produces the per-transfer wait count. It contains the LFSR, the WAIT_MODE selection and the modulo.

## Test plan
- Default parameters: NONSEQ read of 0x10 -> hrdata=0x2 in cycle N+1, hready never low, stat_rd=1.
- Write 0xDEAD_BEEF_0123_4567 to 0x8 (hsize=3), then read 0x8 back-to-back -> forwarded 0xDEAD_BEEF_0123_4567, zero wait.
- Byte write 0xAA to 0x21 (hsize=0), then read 0x20 -> 0x0000_0000_0000_AA04.
- Read 0xF000_0004, and separately a halfword write to 0x3 -> each gives hready 0/1 with hresp=ERROR twice; memory unchanged; stat_err=2.
- WAIT_MODE=0, WAIT_CYCLES=3: 4-beat INCR4 read -> each beat has 3 hready-low cycles; beats return 0,1,2,3 from address 0.
- Reset asserted during the WAIT of a write -> hready=1 and hresp=OKAY immediately; a read of that address after reset returns its init value.
